// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, FSM states and MEM/WB record for the memory access stage
package mem_stage_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;
    localparam int REG_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    // Payload carried from MEM into WB; validity travels beside it.
    typedef struct packed {
        logic [ADDR_W-1:0] alu_out;
        logic [REG_W-1:0]  wa3;
        logic              pc_src;
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] read_data;
    } wb_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/acknowledge bus
// master: stage side (drives mem_req/mem_we/mem_addr/mem_wdata, receives mem_rdata/mem_ack)
// slave : memory side (the reverse directions)
interface mem_access_stage_if;
    import mem_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_wb_register.sv
// rtl/mem_wb_register.sv - MEM/WB pipeline register
// Ports: clk, rst_n (async active-low), load (payload enable), valid_d (valid, loaded every edge),
//        d (payload in), valid / q (registered outputs).
module mem_wb_register
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic valid_d,
    input  wb_t  d,
    output logic valid,
    output wb_t  q
);

    // Valid follows the stage every cycle so bubbles are inserted; the payload
    // only changes when a real entry retires, leaving stale fields untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= valid_d;
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage with stalling data-memory access and timeout abort
// Ports: clk, rst_n (async active-low); MEM inputs validM, A, WD, WA3M, PCSrcM, regWriteM,
//        memWriteM, memToRegM; mem (memory bus, master); stallM; WB outputs validW, readDataW,
//        aluOutW, WA3W, PCSrcW, regWriteW, memToRegW; memErr (sticky timeout flag).
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                validM,
    input  logic [ADDR_W-1:0]   A,
    input  logic [DATA_W-1:0]   WD,
    input  logic [REG_W-1:0]    WA3M,
    input  logic                PCSrcM,
    input  logic                regWriteM,
    input  logic                memWriteM,
    input  logic                memToRegM,
    mem_access_stage_if.master  mem,
    output logic                stallM,
    output logic                validW,
    output logic [DATA_W-1:0]   readDataW,
    output logic [ADDR_W-1:0]   aluOutW,
    output logic [REG_W-1:0]    WA3W,
    output logic                PCSrcW,
    output logic                regWriteW,
    output logic                memToRegW,
    output logic                memErr
);

    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [REG_W-1:0] lat_wa3;
    logic             lat_pc_src;
    logic             lat_reg_write;
    logic             lat_mem_to_reg;

    logic mem_op;
    logic wb_load;
    logic wb_valid_d;
    wb_t  wb_d;
    wb_t  wb_q;

    assign mem_op = validM && (memWriteM || memToRegM);

    // Gated by rst_n so a held upstream memory op cannot assert stall during reset.
    assign stallM = rst_n && (((state == ST_IDLE) && mem_op) ||
                              ((state == ST_WAIT) && !mem.mem_ack));

    always_comb begin
        wb_load    = 1'b0;
        wb_valid_d = 1'b0;
        wb_d       = '0;
        case (state)
            ST_IDLE: begin
                if (validM && !mem_op) begin
                    wb_load    = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_d       = '{alu_out: A, wa3: WA3M, pc_src: PCSrcM,
                                   reg_write: regWriteM, mem_to_reg: memToRegM,
                                   read_data: '0};
                end
            end
            ST_WAIT: begin
                // The address register doubles as the latched ALU result.
                if (mem.mem_ack) begin
                    wb_load    = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_d       = '{alu_out: mem.mem_addr, wa3: lat_wa3, pc_src: lat_pc_src,
                                   reg_write: lat_reg_write, mem_to_reg: lat_mem_to_reg,
                                   read_data: lat_mem_to_reg ? mem.mem_rdata : '0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            lat_wa3        <= '0;
            lat_pc_src     <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            memErr         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        mem.mem_req    <= 1'b1;
                        mem.mem_we     <= memWriteM;
                        mem.mem_addr   <= A;
                        mem.mem_wdata  <= WD;
                        lat_wa3        <= WA3M;
                        lat_pc_src     <= PCSrcM;
                        lat_reg_write  <= regWriteM;
                        lat_mem_to_reg <= memToRegM;
                        wait_cnt       <= '0;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack on the final allowed cycle wins over the timeout.
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem.mem_req <= 1'b0;
                        memErr      <= 1'b1;
                        state       <= ST_ABORT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_wb_register u_mem_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wb_load),
        .valid_d (wb_valid_d),
        .d       (wb_d),
        .valid   (validW),
        .q       (wb_q)
    );

    assign aluOutW   = wb_q.alu_out;
    assign WA3W      = wb_q.wa3;
    assign PCSrcW    = wb_q.pc_src;
    assign regWriteW = wb_q.reg_write;
    assign memToRegW = wb_q.mem_to_reg;
    assign readDataW = wb_q.read_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              validM;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] WD;
    logic [REG_W-1:0]  WA3M;
    logic              PCSrcM, regWriteM, memWriteM, memToRegM;
    logic              stallM, validW;
    logic [DATA_W-1:0] readDataW;
    logic [ADDR_W-1:0] aluOutW;
    logic [REG_W-1:0]  WA3W;
    logic              PCSrcW, regWriteW, memToRegW, memErr;

    int  n_tests = 0;
    int  n_fail  = 0;
    wb_t sb[$];
    wb_t mon_e;
    int  stalls, reqs;

    mem_access_stage_if mif ();

    mem_access_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .validM(validM), .A(A), .WD(WD), .WA3M(WA3M),
        .PCSrcM(PCSrcM), .regWriteM(regWriteM), .memWriteM(memWriteM), .memToRegM(memToRegM),
        .mem(mif), .stallM(stallM), .validW(validW), .readDataW(readDataW),
        .aluOutW(aluOutW), .WA3W(WA3W), .PCSrcW(PCSrcW), .regWriteW(regWriteW),
        .memToRegW(memToRegW), .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every cycle with validW=1 is one retirement; it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && validW === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_retire", 32'(validW), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_alu_out",    32'(aluOutW),   32'(mon_e.alu_out));
                check("wb_wa3",        32'(WA3W),      32'(mon_e.wa3));
                check("wb_pc_src",     32'(PCSrcW),    32'(mon_e.pc_src));
                check("wb_reg_write",  32'(regWriteW), 32'(mon_e.reg_write));
                check("wb_mem_to_reg", 32'(memToRegW), 32'(mon_e.mem_to_reg));
                check("wb_read_data",  32'(readDataW), 32'(mon_e.read_data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [15:0] a, input logic [23:0] wd,
                          input logic [3:0] wa3, input logic pcs, input logic rw,
                          input logic mw, input logic mtr);
        validM = v; A = a; WD = wd; WA3M = wa3;
        PCSrcM = pcs; regWriteM = rw; memWriteM = mw; memToRegM = mtr;
    endtask

    task automatic set_idle();
        set_op(1'b0, 16'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after an edge with a memory op driven in IDLE. Acks after no_ack
    // un-acked WAIT cycles; returns stall and request cycle counts. Upstream inputs
    // are scrambled during WAIT to show they are ignored.
    task automatic run_access(input int no_ack, input logic [23:0] rdata,
                              input logic [15:0] ea, input logic [23:0] ewd, input logic ewe,
                              output int st, output int rq);
        int wc;
        bit done;
        st = 0; rq = 0; wc = 0; done = 1'b0;
        @(negedge clk);
        if (stallM) st++;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (!mif.mem_req) begin
                done = 1'b1;
            end else begin
                mif.mem_ack   = (wc == no_ack);
                mif.mem_rdata = rdata;
                if (wc == 0) begin
                    A = ~A; WD = ~WD; WA3M = ~WA3M;
                end
                @(negedge clk);
                rq++;
                if (stallM) st++;
                check("wait_mem_addr",  32'(mif.mem_addr),  32'(ea));
                check("wait_mem_wdata", 32'(mif.mem_wdata), 32'(ewd));
                check("wait_mem_we",    32'(mif.mem_we),    32'(ewe));
                wc++;
            end
        end
        if (!done) check("access_bound", 32'(mif.mem_req), 32'd0);
        mif.mem_ack = 1'b0;
        set_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        set_op(1'b1, 16'h0040, 24'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1);
        #12;
        check("rst_stall",   32'(stallM),      32'd0);
        check("rst_mem_req", 32'(mif.mem_req), 32'd0);
        check("rst_validW",  32'(validW),      32'd0);
        check("rst_memErr",  32'(memErr),      32'd0);
        check("rst_rdata",   32'(readDataW),   32'd0);
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Plain op
        set_op(1'b1, 16'h0012, 24'h0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        sb.push_back('{alu_out: 16'h0012, wa3: 4'd3, pc_src: 1'b0, reg_write: 1'b1,
                       mem_to_reg: 1'b0, read_data: 24'h0});
        @(negedge clk);
        check("plain_stall_idle", 32'(stallM), 32'd0);
        tick();
        set_idle();
        @(negedge clk);
        check("plain_validW", 32'(validW), 32'd1);
        check("plain_stall_after", 32'(stallM), 32'd0);
        tick();

        // Load, ack after 3 un-acked WAIT cycles
        set_op(1'b1, 16'h0040, 24'h0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        sb.push_back('{alu_out: 16'h0040, wa3: 4'd5, pc_src: 1'b0, reg_write: 1'b1,
                       mem_to_reg: 1'b1, read_data: 24'hABCDEF});
        run_access(3, 24'hABCDEF, 16'h0040, 24'h0, 1'b0, stalls, reqs);
        check("load_stall_cycles", 32'(stalls), 32'd4);
        check("load_req_cycles",   32'(reqs),   32'd4);
        @(negedge clk);
        check("load_validW", 32'(validW), 32'd1);
        tick();

        // Store, ack in the first WAIT cycle; rdata must not leak into readDataW
        set_op(1'b1, 16'h0080, 24'h123456, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        sb.push_back('{alu_out: 16'h0080, wa3: 4'd0, pc_src: 1'b0, reg_write: 1'b0,
                       mem_to_reg: 1'b0, read_data: 24'h0});
        run_access(0, 24'hDEAD00, 16'h0080, 24'h123456, 1'b1, stalls, reqs);
        check("store_stall_cycles", 32'(stalls), 32'd1);
        check("store_req_cycles",   32'(reqs),   32'd1);
        @(negedge clk);
        check("store_validW", 32'(validW), 32'd1);
        tick();

        // Ack on the 15th WAIT cycle completes normally
        set_op(1'b1, 16'h0100, 24'h0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        sb.push_back('{alu_out: 16'h0100, wa3: 4'd7, pc_src: 1'b1, reg_write: 1'b1,
                       mem_to_reg: 1'b1, read_data: 24'h5A5A5A});
        run_access(14, 24'h5A5A5A, 16'h0100, 24'h0, 1'b0, stalls, reqs);
        check("late_ack_stall_cycles", 32'(stalls), 32'd15);
        check("late_ack_req_cycles",   32'(reqs),   32'd15);
        @(negedge clk);
        check("late_ack_memErr", 32'(memErr), 32'd0);
        tick();

        // No ack: timeout, ABORT, sticky error, op never retires
        set_op(1'b1, 16'h0200, 24'h0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        run_access(99, 24'h111111, 16'h0200, 24'h0, 1'b0, stalls, reqs);
        check("timeout_stall_cycles", 32'(stalls), 32'd16);
        check("timeout_req_cycles",   32'(reqs),   32'd15);
        @(negedge clk);
        check("abort_stall",   32'(stallM),      32'd0);
        check("abort_memErr",  32'(memErr),      32'd1);
        check("abort_mem_req", 32'(mif.mem_req), 32'd0);
        check("abort_validW",  32'(validW),      32'd0);
        tick();
        @(negedge clk);
        check("post_abort_validW", 32'(validW), 32'd0);
        check("post_abort_memErr", 32'(memErr), 32'd1);
        tick();

        // Plain op accepted normally after abort
        set_op(1'b1, 16'h0033, 24'h0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        sb.push_back('{alu_out: 16'h0033, wa3: 4'd9, pc_src: 1'b1, reg_write: 1'b1,
                       mem_to_reg: 1'b0, read_data: 24'h0});
        @(negedge clk);
        check("plain2_stall", 32'(stallM), 32'd0);
        tick();
        set_idle();
        @(negedge clk);
        check("plain2_validW", 32'(validW), 32'd1);
        check("sticky_memErr", 32'(memErr), 32'd1);
        tick();

        // Reset pulsed mid-WAIT
        set_op(1'b1, 16'h0300, 24'h0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("pre_rst_mem_req", 32'(mif.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req",  32'(mif.mem_req),  32'd0);
        check("async_rst_stall",    32'(stallM),       32'd0);
        check("async_rst_memErr",   32'(memErr),       32'd0);
        check("async_rst_aluOutW",  32'(aluOutW),      32'd0);
        check("async_rst_WA3W",     32'(WA3W),         32'd0);
        check("async_rst_mem_addr", 32'(mif.mem_addr), 32'd0);
        check("async_rst_validW",   32'(validW),       32'd0);
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 24'h777777;
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_mem_req", 32'(mif.mem_req), 32'd0);
        check("post_rst_stall",   32'(stallM),      32'd0);
        tick();
        check("post_rst_validW",  32'(validW),      32'd0);
        check("post_rst_rdata",   32'(readDataW),   32'd0);
        mif.mem_ack = 1'b0;
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL expose parameter TIMEOUT, default 15, meaning the maximum WAIT cycles without mem_ack before an access is aborted (range 1..15).
REQ-002 SHALL expose clk  input  1  system clock, all state updates on posedge.
REQ-003 SHALL expose rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL expose the MEM-stage inputs:
- validM  input  1  MEM-stage entry valid.
- A  input  16  ALU result / memory address.
- WD  input  24  store data.
- WA3M  input  4  destination register.
- PCSrcM, regWriteM, memWriteM, memToRegM  input  1 each  control.
REQ-005 SHALL expose the data-memory side:
- mem_req  output  1  access request.
- mem_we  output  1  write enable.
- mem_addr  output  16  address.
- mem_wdata  output  24  write data.
- mem_rdata  input  24  read data.
- mem_ack  input  1  access complete.
REQ-006 SHALL expose the pipeline outputs:
- stallM  output  1  freeze upstream stages.
- validW  output  1  WB entry valid.
- readDataW  output  24  load data.
- aluOutW  output  16  A passed through.
- WA3W  output  4  destination register.
- PCSrcW, regWriteW, memToRegW  output  1 each  control.
- memErr  output  1  sticky timeout error.

Function
REQ-007 A memory op SHALL be validM && (memWriteM || memToRegM); any other valid entry is a plain op.
REQ-008 The FSM SHALL have three states (IDLE, WAIT, ABORT), and reset SHALL enter IDLE.
REQ-009 In IDLE with a plain op, the MEM/WB register SHALL load on the next edge (latency 1), with validW=1, readDataW=0 and stallM=0.
REQ-010 In IDLE with a memory op, stallM SHALL be 1 combinationally, and the next edge SHALL register mem_req=1, mem_we=memWriteM, mem_addr=A, mem_wdata=WD, latch the op's control and WA3M internally, clear the wait counter, and enter WAIT.
REQ-011 In IDLE with validM=0, the next edge SHALL load validW=0 and leave the other W outputs unchanged.
REQ-012 In WAIT, mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable, and stallM SHALL equal !mem_ack.
REQ-013 mem_ack SHALL be sampled only in WAIT; an ack in IDLE or ABORT SHALL be ignored.
REQ-014 On a WAIT cycle with mem_ack=1, the next edge SHALL do all of the following:
- load the MEM/WB register from the latched op, with validW=1.
- load readDataW with mem_rdata for loads, or 0 for stores.
- drop mem_req.
- enter IDLE.
REQ-015 Each WAIT cycle without mem_ack SHALL increment a 4-bit wait counter; when the counter equals TIMEOUT-1 and mem_ack=0, the next edge SHALL drop mem_req, set memErr, and enter ABORT.
REQ-016 ABORT SHALL last exactly one cycle with stallM=0, and the next edge SHALL load validW=0 and enter IDLE; the aborted op SHALL never reach WB.
REQ-017 mem_ack arriving in the same cycle the counter reaches TIMEOUT-1 SHALL take priority, so the access completes normally.
REQ-018 memErr SHALL remain 1 until reset.
REQ-019 While stallM=1 the block SHALL ignore changes on the MEM inputs; the upstream stage holds them.
REQ-020 Minimum memory-op stall SHALL be 1 cycle (ack in the first WAIT cycle), and the total stall SHALL equal 1 + the number of WAIT cycles without ack.

Reset
REQ-021 Asserting rst_n=0 SHALL asynchronously force all of the following, including mid-access:
- state to IDLE and the wait counter to 0.
- mem_req, mem_we, mem_addr, mem_wdata, validW, readDataW, aluOutW, WA3W, PCSrcW, regWriteW, memToRegW and memErr to 0.
REQ-022 stallM SHALL be 0 during reset.
REQ-023 After rst_n rises, the first posedge SHALL evaluate IDLE rules normally.

Structure
REQ-024 The FSM state enum and the field widths (ADDR_W=16, DATA_W=24, REG_W=4) SHALL live in a shared package mem_stage_pkg.
REQ-025 The MEM/WB output register SHALL be a sub-module mem_wb_register: async active-low reset, load enable, 1-bit valid and the data/control fields.
REQ-026 The FSM, wait counter and memory-request registers SHALL reside in mem_access_stage.

Verification
REQ-027 Plain op (A=16'h0012, WA3M=3, regWriteM=1) SHALL produce, one edge later, validW=1, aluOutW=16'h0012, WA3W=3, readDataW=0, with stallM=0 throughout.
REQ-028 Load from A=16'h0040 with ack after 3 WAIT cycles (rdata=24'hABCDEF) SHALL produce:
- mem_addr=16'h0040 and mem_we=0 held for 4 cycles.
- stallM high for 4 cycles.
- readDataW=24'hABCDEF, memToRegW=1.
REQ-029 Store of WD=24'h123456 with ack in the first WAIT cycle SHALL produce mem_we=1, mem_wdata=24'h123456, a stall of exactly 1 cycle, and validW=1 with readDataW=0.
REQ-030 No ack with TIMEOUT=15 SHALL produce mem_req high for 15 cycles, then ABORT, memErr=1 (sticky), validW=0, and the next plain op accepted normally.
REQ-031 Ack on the 15th WAIT cycle SHALL complete normally with memErr=0.
REQ-032 rst_n pulsed low in WAIT SHALL make mem_req and stallM drop immediately (asynchronously) and set all outputs to 0; an ack after release SHALL be ignored.
